// File: rtl/sum_accumulator_if.sv
// rtl/sum_accumulator_if.sv - beat input and block result handshake bundle for sum_accumulator
// Purpose: groups the input beat stream and the result port into one bundle.
// Signals:
//   in_valid/in_ready/in_data         beat stream, master -> slave
//   out_valid/out_ready/out_sum/out_ovf  block result, slave -> master
// Modports: slave = accumulator side, master = producer/consumer side.
interface sum_accumulator_if #(
    parameter int IN_W  = 3,
    parameter int ACC_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic             out_ovf;

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_sum,
        output out_ovf
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_sum,
        input  out_ovf
    );
endinterface

// File: rtl/sum_accumulator.sv
// rtl/sum_accumulator.sv - accumulates N unsigned beats into a held block total with overflow flag
// Purpose: collects N beats from the adder stream, then presents the block total and an
//   overflow flag until the consumer takes it.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   clr    synchronous clear, overrides any beat or result handshake in the same cycle
//   bus    sum_accumulator_if slave: in_valid/in_ready/in_data, out_valid/out_ready/out_sum/out_ovf
//   busy   partial block in progress or result pending
module sum_accumulator #(
    parameter int IN_W  = 3,
    parameter int ACC_W = 8,
    parameter int N     = 4,
    parameter int SAT   = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    sum_accumulator_if.slave    bus,
    output logic                busy
);
    localparam int CNT_W = $clog2(N + 1);

    typedef enum logic {
        S_ACC  = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t             state_q;
    logic [ACC_W-1:0]   acc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               ovf_q;
    logic               out_valid_q;
    logic [ACC_W-1:0]   out_sum_q;
    logic               out_ovf_q;

    logic [ACC_W:0]     nxt;
    logic [ACC_W-1:0]   acc_d;
    logic               ovf_d;
    logic               last_beat;

    // One extra bit catches the carry out of the accumulator.
    assign nxt = {1'b0, acc_q} + {{(ACC_W + 1 - IN_W){1'b0}}, bus.in_data};

    // A saturated accumulator stays at all-ones: adding any beat either carries
    // (re-saturates) or adds zero.
    always_comb begin
        acc_d = nxt[ACC_W-1:0];
        if (nxt[ACC_W] && (SAT != 0)) begin
            acc_d = '1;
        end
    end

    assign ovf_d     = ovf_q | nxt[ACC_W];
    assign last_beat = (cnt_q == CNT_W'(N - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_ACC;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_ovf_q   <= 1'b0;
        end else if (clr) begin
            state_q     <= S_ACC;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                S_ACC: begin
                    if (bus.in_valid) begin
                        if (last_beat) begin
                            // Result includes this beat; start the next block clean.
                            out_sum_q   <= acc_d;
                            out_ovf_q   <= ovf_d;
                            out_valid_q <= 1'b1;
                            state_q     <= S_HOLD;
                            acc_q       <= '0;
                            cnt_q       <= '0;
                            ovf_q       <= 1'b0;
                        end else begin
                            acc_q <= acc_d;
                            ovf_q <= ovf_d;
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                S_HOLD: begin
                    // out_sum/out_ovf are left untouched so they keep their value after the handshake.
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_ACC;
                    end
                end
                default: begin
                    state_q <= S_ACC;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state_q == S_ACC);
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_ovf   = out_ovf_q;
    assign busy          = (cnt_q != '0) || out_valid_q;
endmodule

// File: tb/tb_sum_accumulator.sv
// tb/tb_sum_accumulator.sv - self-checking bench for sum_accumulator over four parameter sets
module tb_sum_accumulator;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr;
    logic       in_valid;
    logic [2:0] in_data;
    logic       out_ready;
    logic       busy0, busy1, busy2, busy3;

    always #5 clk = ~clk;

    // u0: ACC_W=8 N=4 wrap, u1: ACC_W=4 N=4 wrap, u2: ACC_W=4 N=4 sat, u3: ACC_W=8 N=1 wrap
    sum_accumulator_if #(.IN_W(3), .ACC_W(8)) if0 ();
    sum_accumulator_if #(.IN_W(3), .ACC_W(4)) if1 ();
    sum_accumulator_if #(.IN_W(3), .ACC_W(4)) if2 ();
    sum_accumulator_if #(.IN_W(3), .ACC_W(8)) if3 ();

    assign if0.in_valid = in_valid;  assign if0.in_data = in_data;  assign if0.out_ready = out_ready;
    assign if1.in_valid = in_valid;  assign if1.in_data = in_data;  assign if1.out_ready = out_ready;
    assign if2.in_valid = in_valid;  assign if2.in_data = in_data;  assign if2.out_ready = out_ready;
    assign if3.in_valid = in_valid;  assign if3.in_data = in_data;  assign if3.out_ready = out_ready;

    sum_accumulator #(.IN_W(3), .ACC_W(8), .N(4), .SAT(0)) u0 (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(if0), .busy(busy0));
    sum_accumulator #(.IN_W(3), .ACC_W(4), .N(4), .SAT(0)) u1 (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(if1), .busy(busy1));
    sum_accumulator #(.IN_W(3), .ACC_W(4), .N(4), .SAT(1)) u2 (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(if2), .busy(busy2));
    sum_accumulator #(.IN_W(3), .ACC_W(8), .N(1), .SAT(0)) u3 (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(if3), .busy(busy3));

    logic [7:0] a_sum [4];
    logic       a_rdy [4];
    logic       a_val [4];
    logic       a_ovf [4];
    logic       a_busy[4];

    assign a_sum[0] = if0.out_sum;          assign a_sum[1] = {4'b0, if1.out_sum};
    assign a_sum[2] = {4'b0, if2.out_sum};  assign a_sum[3] = if3.out_sum;
    assign a_rdy[0] = if0.in_ready;  assign a_rdy[1] = if1.in_ready;  assign a_rdy[2] = if2.in_ready;  assign a_rdy[3] = if3.in_ready;
    assign a_val[0] = if0.out_valid; assign a_val[1] = if1.out_valid; assign a_val[2] = if2.out_valid; assign a_val[3] = if3.out_valid;
    assign a_ovf[0] = if0.out_ovf;   assign a_ovf[1] = if1.out_ovf;   assign a_ovf[2] = if2.out_ovf;   assign a_ovf[3] = if3.out_ovf;
    assign a_busy[0] = busy0; assign a_busy[1] = busy1; assign a_busy[2] = busy2; assign a_busy[3] = busy3;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: block-level view (beat count, running integer total, result latch).
    int m_accw[4];
    int m_n   [4];
    int m_sat [4];
    int m_cnt [4];
    int m_tot [4];
    int m_osum[4];
    bit m_hold[4];
    bit m_oovf[4];

    typedef struct {
        int b[4];
        int sum8;
        int ovf8;
        int sum4w;
        int sum4s;
        int ovf4;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_cnt[i] = 0; m_tot[i] = 0; m_osum[i] = 0; m_hold[i] = 1'b0; m_oovf[i] = 1'b0;
        end
    endtask

    task automatic model_edge();
        int maxv;
        if (clr) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 4; i++) begin
            if (m_hold[i]) begin
                if (out_ready) m_hold[i] = 1'b0;
            end else if (in_valid) begin
                m_tot[i] += int'(in_data);
                m_cnt[i]++;
                if (m_cnt[i] == m_n[i]) begin
                    maxv      = (1 << m_accw[i]) - 1;
                    m_oovf[i] = (m_tot[i] > maxv);
                    if (!m_oovf[i])          m_osum[i] = m_tot[i];
                    else if (m_sat[i] != 0)  m_osum[i] = maxv;
                    else                     m_osum[i] = m_tot[i] % (maxv + 1);
                    m_hold[i] = 1'b1;
                    m_cnt[i]  = 0;
                    m_tot[i]  = 0;
                end
            end
        end
    endtask

    task automatic check_all();
        logic [11:0] act;
        logic [11:0] exp;
        for (int i = 0; i < 4; i++) begin
            act = {a_rdy[i], a_val[i], a_busy[i], a_ovf[i], a_sum[i]};
            exp = {~m_hold[i], m_hold[i], (m_cnt[i] != 0) || m_hold[i], m_oovf[i], 8'(m_osum[i])};
            check($sformatf("model_u%0d {rdy,val,busy,ovf,sum}", i), 32'(act), 32'(exp));
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic beat(input int d);
        in_valid = 1'b1;
        in_data  = 3'(d);
        tick();
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
    endtask

    initial begin
        m_accw = '{8, 4, 4, 8};
        m_n    = '{4, 4, 4, 1};
        m_sat  = '{0, 0, 1, 0};
        vecs[0] = '{b: '{3, 5, 7, 1}, sum8: 16, ovf8: 0, sum4w: 0,  sum4s: 15, ovf4: 1};
        vecs[1] = '{b: '{1, 1, 1, 1}, sum8: 4,  ovf8: 0, sum4w: 4,  sum4s: 4,  ovf4: 0};
        vecs[2] = '{b: '{7, 7, 7, 7}, sum8: 28, ovf8: 0, sum4w: 12, sum4s: 15, ovf4: 1};
        vecs[3] = '{b: '{0, 0, 0, 0}, sum8: 0,  ovf8: 0, sum4w: 0,  sum4s: 0,  ovf4: 0};
        vecs[4] = '{b: '{2, 2, 2, 2}, sum8: 8,  ovf8: 0, sum4w: 8,  sum4s: 8,  ovf4: 0};
        vecs[5] = '{b: '{7, 7, 7, 6}, sum8: 27, ovf8: 0, sum4w: 11, sum4s: 15, ovf4: 1};

        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = 3'd0; out_ready = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_all();
        check("reset_in_ready", 32'(if0.in_ready), 32'd1);
        check("reset_out_valid", 32'(if0.out_valid), 32'd0);
        rst_n = 1'b1;

        // Mid-block reset discards the partial sum.
        out_ready = 1'b1;
        beat(1); beat(2);
        check("t1_busy_partial", 32'(busy0), 32'd1);
        in_valid = 1'b0;
        do_reset();
        check("t1_busy_after_reset", 32'(busy0), 32'd0);
        check("t1_in_ready_after_reset", 32'(if0.in_ready), 32'd1);
        check("t1_sum_after_reset", 32'(if0.out_sum), 32'd0);
        for (int k = 0; k < 4; k++) beat(1);
        check("t1_out_valid", 32'(if0.out_valid), 32'd1);
        check("t1_out_sum", 32'(if0.out_sum), 32'd4);
        drain();

        // Table of blocks applied back to back on the N=4 instances.
        for (int v = 0; v < 6; v++) begin
            out_ready = 1'b1;
            for (int k = 0; k < 4; k++) begin
                beat(vecs[v].b[k]);
                if (k < 3) check($sformatf("vec%0d_no_valid_beat%0d", v, k), 32'(if0.out_valid), 32'd0);
            end
            check($sformatf("vec%0d_valid", v), 32'(if0.out_valid), 32'd1);
            check($sformatf("vec%0d_sum8", v),  32'(if0.out_sum), 32'(vecs[v].sum8));
            check($sformatf("vec%0d_ovf8", v),  32'(if0.out_ovf), 32'(vecs[v].ovf8));
            check($sformatf("vec%0d_sum4w", v), 32'(if1.out_sum), 32'(vecs[v].sum4w));
            check($sformatf("vec%0d_sum4s", v), 32'(if2.out_sum), 32'(vecs[v].sum4s));
            check($sformatf("vec%0d_ovf4w", v), 32'(if1.out_ovf), 32'(vecs[v].ovf4));
            check($sformatf("vec%0d_ovf4s", v), 32'(if2.out_ovf), 32'(vecs[v].ovf4));
            drain();
            check($sformatf("vec%0d_valid_one_cycle", v), 32'(if0.out_valid), 32'd0);
            check($sformatf("vec%0d_sum_kept", v), 32'(if0.out_sum), 32'(vecs[v].sum8));
        end

        // Backpressure: result held, beats refused, then handshake.
        out_ready = 1'b1;
        beat(3); beat(5); beat(7);
        out_ready = 1'b0;
        beat(1);
        for (int k = 0; k < 5; k++) begin
            beat(5);
            check($sformatf("t3_in_ready_%0d", k), 32'(if0.in_ready), 32'd0);
            check($sformatf("t3_sum_stable_%0d", k), 32'(if0.out_sum), 32'd16);
            check($sformatf("t3_valid_held_%0d", k), 32'(if0.out_valid), 32'd1);
        end
        out_ready = 1'b1;
        beat(5);
        check("t3_handshake_valid", 32'(if0.out_valid), 32'd0);
        check("t3_handshake_no_beat", 32'(busy0), 32'd0);
        beat(5);
        check("t3_next_beat_taken", 32'(busy0), 32'd1);
        beat(1); beat(1); beat(1);
        check("t3_next_sum", 32'(if0.out_sum), 32'd8);
        drain();

        // Synchronous clear drops the beat presented with it.
        beat(6); beat(6);
        clr = 1'b1;
        beat(6);
        clr = 1'b0;
        check("t5_busy_after_clr", 32'(busy0), 32'd0);
        check("t5_sum_after_clr", 32'(if0.out_sum), 32'd0);
        for (int k = 0; k < 4; k++) beat(2);
        check("t5_sum", 32'(if0.out_sum), 32'd8);
        drain();

        // N=1: every accepted beat is a result, with a HOLD cycle in between.
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            beat(5);
            check($sformatf("t6_n1_valid_%0d", k), 32'(if3.out_valid), 32'((k % 2) == 0));
            check($sformatf("t6_n1_sum_%0d", k), 32'(if3.out_sum), 32'd5);
        end
        drain();

        // Random traffic with bubbles, backpressure, clears and occasional resets.
        for (int c = 0; c < 600; c++) begin
            in_valid  = (($urandom % 3) != 0);
            in_data   = 3'($urandom % 8);
            out_ready = (($urandom % 4) != 0);
            clr       = (($urandom % 64) == 0);
            if (($urandom % 250) == 0) begin
                clr      = 1'b0;
                in_valid = 1'b0;
                do_reset();
            end else begin
                tick();
            end
        end
        clr = 1'b0;
        in_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
